// File: rtl/csr_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// csr_seq_ctrl_pkg
// Shared CSR definitions (csr_defs) used by the CSR sequencer and by anything
// else that talks to the machine-mode CSR file.
//   - CSR-class op codes presented by the EXU on req_op
//   - Machine-mode CSR addresses touched by the trap sequences
//   - csr_op_legal(): tells whether an op code is one the sequencer handles
// ----------------------------------------------------------------------------
package csr_seq_ctrl_pkg;

  localparam logic [3:0] CSR_OP_RW    = 4'd0;
  localparam logic [3:0] CSR_OP_RS    = 4'd1;
  localparam logic [3:0] CSR_OP_ECALL = 4'd2;
  localparam logic [3:0] CSR_OP_MRET  = 4'd3;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Op codes 4..15 are reserved and get an illegal response.
  function automatic logic csr_op_legal(input logic [3:0] op);
    return (op <= CSR_OP_MRET);
  endfunction

endpackage

// File: rtl/csr_seq_ctrl.sv
// ----------------------------------------------------------------------------
// csr_seq_ctrl
// Multi-cycle sequencer between the EXU and a single-port CSR register file.
// It takes one CSR-class op at a time (csrrw, csrrs, ecall, mret), issues the
// CSR reads/writes in order and returns rd data or a PC redirect target.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_*           EXU request (valid/ready, op, csr addr, rs1 value, pc)
//   resp_*          response held until resp_ready (rdata, redirect, target,
//                   illegal)
//   csr_addr        CSR file address; csr_rdata returns combinationally
//   csr_rdata       CSR file read data
//   csr_wen/wdata   CSR file write strobe/data, written at the clock edge
// ----------------------------------------------------------------------------
module csr_seq_ctrl
  import csr_seq_ctrl_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int CSR_AW      = 12,
  parameter int ECALL_CAUSE = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [CSR_AW-1:0] req_csr_addr,
  input  logic [XLEN-1:0]   req_src1,
  input  logic [XLEN-1:0]   req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_redirect,
  output logic [XLEN-1:0]   resp_target,
  output logic              resp_illegal,
  output logic [CSR_AW-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_wen,
  output logic [XLEN-1:0]   csr_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_T_EPC, S_T_CAUSE, S_T_VEC, S_RESP
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        op_reg, op_next;
  logic [CSR_AW-1:0] addr_reg, addr_next;
  logic [XLEN-1:0]   src1_reg, src1_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [XLEN-1:0]   old_reg, old_next;
  logic [XLEN-1:0]   target_reg, target_next;
  logic              illegal_reg, illegal_next;
  logic              redirect_reg, redirect_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      op_reg       <= '0;
      addr_reg     <= '0;
      src1_reg     <= '0;
      pc_reg       <= '0;
      old_reg      <= '0;
      target_reg   <= '0;
      illegal_reg  <= 1'b0;
      redirect_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      addr_reg     <= addr_next;
      src1_reg     <= src1_next;
      pc_reg       <= pc_next;
      old_reg      <= old_next;
      target_reg   <= target_next;
      illegal_reg  <= illegal_next;
      redirect_reg <= redirect_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    addr_next     = addr_reg;
    src1_next     = src1_reg;
    pc_next       = pc_reg;
    old_next      = old_reg;
    target_next   = target_reg;
    illegal_next  = illegal_reg;
    redirect_next = redirect_reg;
    // rst forces IDLE asynchronously; gating here keeps req_ready low while
    // reset is held even though the state already reads IDLE.
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_redirect = 1'b0;
    resp_target   = '0;
    resp_illegal  = 1'b0;
    csr_addr      = '0;
    csr_wen       = 1'b0;
    csr_wdata     = '0;

    case (state_reg)
      S_IDLE: begin
        req_ready = ~rst;
        if (req_valid && !rst) begin
          op_next       = req_op;
          addr_next     = req_csr_addr;
          src1_next     = req_src1;
          pc_next       = req_pc;
          // Clear results of the previous op so unused fields read as zero.
          old_next      = '0;
          target_next   = '0;
          illegal_next  = 1'b0;
          redirect_next = 1'b0;
          if (!csr_op_legal(req_op)) begin
            illegal_next = 1'b1;
            state_next   = S_RESP;
          end else if (req_op == CSR_OP_ECALL) begin
            state_next = S_T_EPC;
          end else begin
            state_next = S_RD;
          end
        end
      end

      S_RD: begin
        if (op_reg == CSR_OP_MRET) begin
          csr_addr      = CSR_AW'(CSR_MEPC);
          target_next   = csr_rdata;
          redirect_next = 1'b1;
          state_next    = S_RESP;
        end else begin
          // Latched value is reused for the OR in WR; no second read.
          csr_addr   = addr_reg;
          old_next   = csr_rdata;
          state_next = S_WR;
        end
      end

      S_WR: begin
        csr_wen    = 1'b1;
        csr_addr   = addr_reg;
        csr_wdata  = (op_reg == CSR_OP_RW) ? src1_reg : (old_reg | src1_reg);
        state_next = S_RESP;
      end

      S_T_EPC: begin
        csr_wen    = 1'b1;
        csr_addr   = CSR_AW'(CSR_MEPC);
        csr_wdata  = pc_reg;
        state_next = S_T_CAUSE;
      end

      S_T_CAUSE: begin
        csr_wen    = 1'b1;
        csr_addr   = CSR_AW'(CSR_MCAUSE);
        csr_wdata  = XLEN'(ECALL_CAUSE);
        state_next = S_T_VEC;
      end

      S_T_VEC: begin
        // Direct mode only: mode bits [1:0] of mtvec are dropped.
        csr_addr      = CSR_AW'(CSR_MTVEC);
        target_next   = {csr_rdata[XLEN-1:2], 2'b00};
        redirect_next = 1'b1;
        state_next    = S_RESP;
      end

      S_RESP: begin
        resp_valid    = 1'b1;
        resp_rdata    = old_reg;
        resp_redirect = redirect_reg;
        resp_target   = target_reg;
        resp_illegal  = illegal_reg;
        if (resp_ready) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csr_seq_ctrl
// Scoreboard bench: expected responses and expected CSR writes are queued when
// a request is driven and compared when the DUT produces them. A behavioural
// CSR file answers reads combinationally and commits writes at the clock edge.
// ----------------------------------------------------------------------------
module tb_csr_seq_ctrl;
  import csr_seq_ctrl_pkg::*;

  localparam int XLEN   = 64;
  localparam int CSR_AW = 12;

  typedef struct {
    logic [XLEN-1:0] rdata;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic            illegal;
    int              lat;
  } resp_t;

  typedef struct {
    logic [CSR_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [3:0]        req_op;
  logic [CSR_AW-1:0] req_csr_addr;
  logic [XLEN-1:0]   req_src1, req_pc;
  logic              resp_valid, resp_ready;
  logic [XLEN-1:0]   resp_rdata, resp_target;
  logic              resp_redirect, resp_illegal;
  logic [CSR_AW-1:0] csr_addr;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_wen;
  logic [XLEN-1:0]   csr_wdata;

  int n_vec  = 0;
  int n_miss = 0;

  resp_t exp_rq[$];
  wr_t   exp_wq[$];
  wr_t   mon_w;

  logic [XLEN-1:0]   csr_mem [0:4095];
  logic              pl_en = 1'b0;
  logic [CSR_AW-1:0] pl_addr = '0;
  logic [XLEN-1:0]   pl_data = '0;

  always #5 clk = ~clk;

  csr_seq_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW), .ECALL_CAUSE(11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr_addr(req_csr_addr), .req_src1(req_src1), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_redirect(resp_redirect), .resp_target(resp_target),
    .resp_illegal(resp_illegal),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_wdata(csr_wdata)
  );

  // Behavioural CSR file.
  assign csr_rdata = csr_mem[csr_addr];

  always @(posedge clk) begin
    if (csr_wen) csr_mem[csr_addr] <= csr_wdata;
    else if (pl_en) csr_mem[pl_addr] <= pl_data;
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: sampled mid-cycle, the write lands on the next edge.
  always @(negedge clk) begin
    if (csr_wen) begin
      if (exp_wq.size() == 0) begin
        chk("wr_unexpected", {52'd0, csr_addr}, '1);
      end else begin
        mon_w = exp_wq.pop_front();
        chk("wr_addr", {52'd0, csr_addr}, {52'd0, mon_w.addr});
        chk("wr_data", csr_wdata, mon_w.data);
        $display("write addr=%h data=%h", csr_addr, csr_wdata);
      end
    end
  end

  task automatic preload(input logic [CSR_AW-1:0] a, input logic [XLEN-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic push_wr(input logic [CSR_AW-1:0] a, input logic [XLEN-1:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wq.push_back(w);
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [CSR_AW-1:0] a, input logic [XLEN-1:0] src1,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] e_rdata,
                        input logic e_redir, input logic [XLEN-1:0] e_target,
                        input logic e_ill, input int e_lat, input int hold);
    resp_t e, g;
    int lat;
    e.rdata = e_rdata; e.redirect = e_redir; e.target = e_target;
    e.illegal = e_ill; e.lat = e_lat;
    exp_rq.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_csr_addr = a; req_src1 = src1; req_pc = pc;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 20);
    g = exp_rq.pop_front();
    chk("resp_seen", {63'd0, resp_valid}, 64'd1);
    chk("latency", 64'(lat), 64'(g.lat));
    chk("rdata", resp_rdata, g.rdata);
    chk("redirect", {63'd0, resp_redirect}, {63'd0, g.redirect});
    chk("target", resp_target, g.target);
    chk("illegal", {63'd0, resp_illegal}, {63'd0, g.illegal});
    $display("%s op=%0d lat=%0d rdata=%h redirect=%0b target=%h illegal=%0b",
             name, op, lat, resp_rdata, resp_redirect, resp_target, resp_illegal);
    // Stall the consumer; a request presented meanwhile must not be taken.
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, g.rdata);
      chk("hold_target", resp_target, g.target);
      chk("hold_illegal", {63'd0, resp_illegal}, {63'd0, g.illegal});
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_csr_addr = '0;
    req_src1 = '0; req_pc = '0; resp_ready = 1'b0;
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_csr_wen", {63'd0, csr_wen}, 64'd0);
    chk("rst_csr_addr", {52'd0, csr_addr}, 64'd0);
    chk("rst_csr_wdata", csr_wdata, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    preload(CSR_MTVEC, 64'h10);
    preload(CSR_MSTATUS, 64'hA00);

    // 1: csrrw
    push_wr(CSR_MTVEC, 64'h8000_0100);
    run_op("csrrw", CSR_OP_RW, CSR_MTVEC, 64'h8000_0100, 64'h0,
           64'h10, 1'b0, 64'h0, 1'b0, 3, 0);
    chk("mtvec_after_rw", csr_mem[CSR_MTVEC], 64'h8000_0100);

    // 2: csrrs, then csrrs with src1=0 (write still issued)
    push_wr(CSR_MSTATUS, 64'hA08);
    run_op("csrrs", CSR_OP_RS, CSR_MSTATUS, 64'h8, 64'h0,
           64'hA00, 1'b0, 64'h0, 1'b0, 3, 0);
    push_wr(CSR_MSTATUS, 64'hA08);
    run_op("csrrs0", CSR_OP_RS, CSR_MSTATUS, 64'h0, 64'h0,
           64'hA08, 1'b0, 64'h0, 1'b0, 3, 0);

    // 3: ecall
    preload(CSR_MTVEC, 64'h8000_1003);
    push_wr(CSR_MEPC, 64'h8000_0040);
    push_wr(CSR_MCAUSE, 64'd11);
    run_op("ecall", CSR_OP_ECALL, 12'h0, 64'h0, 64'h8000_0040,
           64'h0, 1'b1, 64'h8000_1000, 1'b0, 4, 0);

    // 4: mret
    preload(CSR_MEPC, 64'h8000_0044);
    run_op("mret", CSR_OP_MRET, 12'h0, 64'h0, 64'h0,
           64'h0, 1'b1, 64'h8000_0044, 1'b0, 2, 0);

    // 5: illegal op, consumer stalls for 5 cycles
    run_op("illegal", 4'd7, 12'h300, 64'hFFFF, 64'h1234,
           64'h0, 1'b0, 64'h0, 1'b1, 1, 5);

    // 6: reset during T_CAUSE of an ecall
    preload(CSR_MCAUSE, 64'hDEAD);
    push_wr(CSR_MEPC, 64'h8000_0080);
    @(negedge clk);
    req_valid = 1'b1; req_op = CSR_OP_ECALL; req_pc = 64'h8000_0080;
    @(posedge clk);            // accept -> T_EPC
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);            // mepc written -> T_CAUSE
    #2 rst = 1'b1;
    #1;
    chk("abort_csr_wen", {63'd0, csr_wen}, 64'd0);
    chk("abort_csr_addr", {52'd0, csr_addr}, 64'd0);
    chk("abort_csr_wdata", csr_wdata, 64'd0);
    chk("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("abort_req_ready", {63'd0, req_ready}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_mepc", csr_mem[CSR_MEPC], 64'h8000_0080);
    chk("abort_mcause", csr_mem[CSR_MCAUSE], 64'hDEAD);
    chk("abort_idle_ready", {63'd0, req_ready}, 64'd1);
    repeat (3) @(negedge clk);
    chk("abort_no_resp", {63'd0, resp_valid}, 64'd0);
    $display("reset_abort mepc=%h mcause=%h", csr_mem[CSR_MEPC], csr_mem[CSR_MCAUSE]);

    chk("wr_pending", 64'(exp_wq.size()), 64'd0);
    chk("resp_pending", 64'(exp_rq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
